// File: rtl/ky32_demux4x32_reg.sv
// ============================================================================
// ky32_demux4x32_reg : registered 1-to-4 distributor for 32-bit words with one
// holding slot per port. Optional broadcast via macro KY32_DEMUX_BCAST_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ky32_demux4x32_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_sel,
  input  logic        in_bcast,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data_a,
  output logic [31:0] out_data_b,
  output logic [31:0] out_data_c,
  output logic [31:0] out_data_d,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [3:0]  occupancy
);

  localparam int unsigned c_NPORT = 4;

  logic [3:0]  full_q;
  logic [3:0]  full_d;
  logic [31:0] data_q [c_NPORT];
  logic [31:0] data_d [c_NPORT];

  logic [3:0]  w_drain;
  logic [3:0]  w_can;
  logic [3:0]  w_load;
  logic        w_bcast;
  logic        w_ready;
  logic        w_acc;

`ifdef KY32_DEMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  logic w_unused_bcast;
  assign w_unused_bcast = in_bcast;
  assign w_bcast        = 1'b0;
`endif

  // Ready passes straight through from the consumers so a draining slot can refill on the same edge.
  always_comb begin
    w_drain = full_q & out_ready;
    w_can   = ~full_q | w_drain;
    if (w_bcast) begin
      w_ready = &w_can;
    end else begin
      w_ready = w_can[in_sel];
    end
    in_ready = w_ready & rst_n;
    w_acc    = in_valid & in_ready;
    w_load   = 4'b0000;
    if (w_acc) begin
      if (w_bcast) begin
        w_load = 4'b1111;
      end else begin
        w_load[in_sel] = 1'b1;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    for (int k = 0; k < c_NPORT; k++) begin
      data_d[k] = data_q[k];
      if (w_load[k]) begin
        full_d[k] = 1'b1;
        data_d[k] = in_data;
      end else if (w_drain[k]) begin
        full_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 4'b0000;
      for (int k = 0; k < c_NPORT; k++) begin
        data_q[k] <= 32'h0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < c_NPORT; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid  = full_q;
  assign occupancy  = full_q;
  assign out_data_a = data_q[0];
  assign out_data_b = data_q[1];
  assign out_data_c = data_q[2];
  assign out_data_d = data_q[3];

endmodule

`default_nettype wire
